// File: rtl/backup_sync.sv
// Save-RAM backup sequencer: moves a fixed-size save image between backup RAM
// and the HPS one 512-byte sector at a time, with auto-load on download and timed autosave.
module backup_sync #(
  parameter int SECTOR_BITS = 6,
  parameter int TMR_W = 24,
  parameter logic [TMR_W-1:0] AUTOSAVE_DELAY = TMR_W'(24'd10_000_000)
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        download,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic [63:0] img_size,
  input  logic        load_req,
  input  logic        save_req,
  input  logic        autosave_en,
  input  logic        nvram_we,
  input  logic        sd_ack,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic        ena,
  output logic        loading,
  output logic        busy,
  output logic        dirty,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_FALL} state_t;

  state_t                 state;
  logic [SECTOR_BITS-1:0] sector;
  logic [TMR_W-1:0]       timer;
  logic                   ena_r = 1'b0;
  logic                   download_q;
  logic                   load_q;
  logic                   save_q;
  logic                   ack_q;

  logic download_rise;
  logic download_fall;
  logic load_edge;
  logic save_edge;
  logic ack_rise;
  logic ack_fall;
  logic autoload;
  logic autosave_go;
  logic start;
  logic start_load;
  logic last_sector;

  assign download_rise = download & ~download_q;
  assign download_fall = download_q & ~download;
  assign load_edge     = ena_r & load_req & ~load_q;
  assign save_edge     = ena_r & save_req & ~save_q;
  assign ack_rise      = sd_ack & ~ack_q;
  assign ack_fall      = ack_q & ~sd_ack;
  assign autoload      = download_fall & (img_size != 64'd0) & ena_r;
  assign autosave_go   = (timer == AUTOSAVE_DELAY) & dirty & ena_r & autosave_en;
  assign start         = (state == IDLE) & (autoload | load_edge | save_edge | autosave_go);
  assign start_load    = autoload | load_edge;
  assign last_sector   = &sector;

  // Only the low SECTOR_BITS of the address ever move; the rest stay zero.
  assign sd_lba = 32'(sector);
  assign ena    = ena_r;

  // The image-present flag survives reset so a core reset does not forget the mount.
  always_ff @(posedge clk_sys) begin
    if (download_rise)
      ena_r <= 1'b0;
    if (download & img_mounted & ~img_readonly)
      ena_r <= 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      sector     <= '0;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      busy       <= 1'b0;
      loading    <= 1'b0;
      dirty      <= 1'b0;
      done       <= 1'b0;
      timer      <= '0;
      download_q <= download;
      load_q     <= load_req;
      save_q     <= save_req;
      ack_q      <= sd_ack;
    end else begin
      download_q <= download;
      load_q     <= load_req;
      save_q     <= save_req;
      ack_q      <= sd_ack;
      done       <= 1'b0;

      if (nvram_we || start || !dirty)
        timer <= '0;
      else if (state == IDLE && ena_r && autosave_en && timer != AUTOSAVE_DELAY)
        timer <= timer + 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            sector  <= '0;
            busy    <= 1'b1;
            loading <= start_load;
            sd_rd   <= start_load;
            sd_wr   <= ~start_load;
            state   <= ISSUE;
            if (!start_load)
              dirty <= 1'b0;
          end
        end
        ISSUE: begin
          if (ack_rise) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            state <= WAIT_FALL;
          end
        end
        WAIT_FALL: begin
          if (ack_fall) begin
            if (last_sector) begin
              state   <= IDLE;
              busy    <= 1'b0;
              loading <= 1'b0;
              done    <= 1'b1;
              if (loading)
                dirty <= 1'b0;
            end else begin
              sector <= sector + 1'b1;
              sd_rd  <= loading;
              sd_wr  <= ~loading;
              state  <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A core write always marks the RAM dirty, even in the cycle a save starts.
      if (nvram_we && !loading)
        dirty <= 1'b1;
    end
  end

endmodule

// File: tb/tb_backup_sync.sv
// Bench for backup_sync: an HPS sector responder pops expected requests from a
// scoreboard queue filled when each transfer is triggered.
module tb_backup_sync;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        download;
  logic        img_mounted;
  logic        img_readonly;
  logic [63:0] img_size;
  logic        load_req;
  logic        save_req;
  logic        autosave_en;
  logic        nvram_we;
  logic        sd_ack;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        ena;
  logic        loading;
  logic        busy;
  logic        dirty;
  logic        done;

  typedef struct {
    logic [31:0] lba;
    logic        rd;
    logic        wr;
  } sector_t;

  sector_t sb[$];
  int checks = 0;
  int passes = 0;
  int done_count = 0;

  backup_sync #(
    .SECTOR_BITS(2),
    .TMR_W(24),
    .AUTOSAVE_DELAY(24'd100)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .download(download),
    .img_mounted(img_mounted),
    .img_readonly(img_readonly),
    .img_size(img_size),
    .load_req(load_req),
    .save_req(save_req),
    .autosave_en(autosave_en),
    .nvram_we(nvram_we),
    .sd_ack(sd_ack),
    .sd_lba(sd_lba),
    .sd_rd(sd_rd),
    .sd_wr(sd_wr),
    .ena(ena),
    .loading(loading),
    .busy(busy),
    .dirty(dirty),
    .done(done)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys)
    if (done === 1'b1) done_count++;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected)
      passes++;
    else
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
  endtask

  // Pulse load/save request lines for one cycle, starting and ending on a falling edge.
  task automatic applyStimulus(input logic ld, input logic sv);
    load_req = ld;
    save_req = sv;
    @(negedge clk_sys);
    load_req = 1'b0;
    save_req = 1'b0;
  endtask

  task automatic expectTransfer(input logic is_load, input int n);
    sector_t e;
    for (int i = 0; i < n; i++) begin
      e.lba = i;
      e.rd  = is_load;
      e.wr  = ~is_load;
      sb.push_back(e);
    end
  endtask

  task automatic serviceTransfer(input int n, input bit expect_done);
    sector_t e;
    int cnt;
    for (int s = 0; s < n; s++) begin
      if (sb.size() == 0) begin
        checkOutput("sb_empty", 32'd0, 32'd1);
        return;
      end
      e = sb.pop_front();
      cnt = 0;
      while (!(sd_rd || sd_wr) && cnt < 50) begin
        @(negedge clk_sys);
        cnt++;
      end
      if (cnt >= 50) begin
        checkOutput("req_timeout", cnt, 32'd0);
        return;
      end
      checkOutput("req_lba", sd_lba, e.lba);
      checkOutput("req_rd", sd_rd, e.rd);
      checkOutput("req_wr", sd_wr, e.wr);
      sd_ack = 1'b1;
      @(negedge clk_sys);
      checkOutput("req_clear", {sd_rd, sd_wr}, 32'd0);
      sd_ack = 1'b0;
      @(negedge clk_sys);
      if (s == n - 1 && expect_done) begin
        checkOutput("done_pulse", done, 1'b1);
        checkOutput("busy_end", busy, 1'b0);
        checkOutput("loading_end", loading, 1'b0);
      end
    end
  endtask

  initial begin
    int k;
    bit seen;
    int done_before;
    sector_t e;

    reset = 1'b1; download = 1'b0; img_mounted = 1'b0; img_readonly = 1'b0;
    img_size = 64'd0; load_req = 1'b0; save_req = 1'b0; autosave_en = 1'b0;
    nvram_we = 1'b0; sd_ack = 1'b0;
    repeat (3) @(negedge clk_sys);
    checkOutput("rst_outs", {sd_rd, sd_wr, busy, loading, dirty, done}, 32'd0);
    checkOutput("rst_lba", sd_lba, 32'd0);
    checkOutput("rst_ena", ena, 1'b0);
    reset = 1'b0;
    @(negedge clk_sys);

    // Read-only mount: no enable, no auto-load, manual requests ignored.
    download = 1'b1; img_size = 64'd32768;
    @(negedge clk_sys);
    img_mounted = 1'b1; img_readonly = 1'b1;
    @(negedge clk_sys);
    img_mounted = 1'b0;
    @(negedge clk_sys);
    download = 1'b0;
    @(negedge clk_sys);
    applyStimulus(1'b1, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (sd_rd || sd_wr || busy) seen = 1'b1;
      @(negedge clk_sys);
    end
    checkOutput("ro_no_req", seen, 1'b0);
    checkOutput("ro_ena", ena, 1'b0);

    // Writable mount followed by auto-load on download falling edge.
    download = 1'b1; img_readonly = 1'b0;
    @(negedge clk_sys);
    img_mounted = 1'b1;
    @(negedge clk_sys);
    img_mounted = 1'b0;
    @(negedge clk_sys);
    checkOutput("mount_ena", ena, 1'b1);
    download = 1'b0;
    expectTransfer(1'b1, 4);
    @(negedge clk_sys);
    checkOutput("autoload_busy", {busy, loading}, 32'd3);
    serviceTransfer(4, 1'b1);

    // Core write marks dirty; manual save clears it; write during save re-marks it.
    nvram_we = 1'b1;
    @(negedge clk_sys);
    nvram_we = 1'b0;
    checkOutput("we_dirty", dirty, 1'b1);
    save_req = 1'b1;
    expectTransfer(1'b0, 4);
    @(negedge clk_sys);
    save_req = 1'b0;
    checkOutput("save_start_dirty", dirty, 1'b0);
    checkOutput("save_start_busy", {busy, loading}, 32'd2);
    nvram_we = 1'b1;
    load_req = 1'b1;
    @(negedge clk_sys);
    nvram_we = 1'b0;
    load_req = 1'b0;
    checkOutput("save_we_dirty", dirty, 1'b1);
    serviceTransfer(4, 1'b1);
    repeat (5) @(negedge clk_sys);
    checkOutput("busy_drop_load", {busy, sd_rd, sd_wr}, 32'd0);

    // Simultaneous load and save edges: load wins, and load completion clears dirty.
    expectTransfer(1'b1, 4);
    applyStimulus(1'b1, 1'b1);
    checkOutput("both_loading", loading, 1'b1);
    serviceTransfer(4, 1'b1);
    checkOutput("load_clears_dirty", dirty, 1'b0);

    // Autosave after a single write.
    autosave_en = 1'b1;
    nvram_we = 1'b1;
    @(negedge clk_sys);
    nvram_we = 1'b0;
    k = 0;
    while (!busy && k < 300) begin
      @(negedge clk_sys);
      k++;
    end
    checkOutput("autosave_delay1", k, 32'd101);
    checkOutput("autosave_dirty", dirty, 1'b0);
    expectTransfer(1'b0, 4);
    serviceTransfer(4, 1'b1);

    // A second write 50 cycles in restarts the idle timer.
    nvram_we = 1'b1;
    @(negedge clk_sys);
    nvram_we = 1'b0;
    k = 0;
    while (!busy && k < 400) begin
      nvram_we = (k == 49);
      @(negedge clk_sys);
      k++;
    end
    nvram_we = 1'b0;
    checkOutput("autosave_delay2", k, 32'd151);
    expectTransfer(1'b0, 4);
    serviceTransfer(4, 1'b1);
    autosave_en = 1'b0;

    // Reset while waiting for the ack to fall on the last sector aborts cleanly.
    expectTransfer(1'b0, 4);
    applyStimulus(1'b0, 1'b1);
    serviceTransfer(3, 1'b0);
    e = sb.pop_front();
    k = 0;
    while (!(sd_rd || sd_wr) && k < 50) begin
      @(negedge clk_sys);
      k++;
    end
    checkOutput("abort_lba", sd_lba, e.lba);
    sd_ack = 1'b1;
    @(negedge clk_sys);
    checkOutput("abort_wait", {sd_rd, sd_wr, busy}, 32'd1);
    done_before = done_count;
    reset = 1'b1;
    @(negedge clk_sys);
    checkOutput("abort_outs", {sd_rd, sd_wr, busy}, 32'd0);
    checkOutput("abort_lba0", sd_lba, 32'd0);
    sd_ack = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (5) @(negedge clk_sys);
    checkOutput("abort_no_done", done_count, done_before);
    checkOutput("abort_idle", {busy, sd_rd, sd_wr}, 32'd0);
    checkOutput("reset_keeps_ena", ena, 1'b1);
    checkOutput("done_total", done_count, 32'd5);

    // A new download clears the image-present flag.
    download = 1'b1;
    @(negedge clk_sys);
    checkOutput("dl_rise_ena", ena, 1'b0);
    download = 1'b0;
    repeat (3) @(negedge clk_sys);
    checkOutput("dl_no_load", busy, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/backup_sync.md
BACKUP_SYNC -- requirements
Module: backup_sync

Interface
REQ-001 Parameter SECTOR_BITS, default 6: transfer length is 2^SECTOR_BITS sectors of 512 bytes.
REQ-002 Parameter TMR_W, default 24: autosave idle-timer width.
REQ-003 Parameter AUTOSAVE_DELAY, default 24'd10_000_000: idle clk_sys cycles before autosave.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 download  in  1  ROM download in progress (level).
REQ-008 img_mounted  in  1  save-image mount strobe.
REQ-009 img_readonly  in  1  mounted image is read-only.
REQ-010 img_size  in  64  mounted image size in bytes.
REQ-011 load_req  in  1  manual load request; rising edge acts.
REQ-012 save_req  in  1  manual save request; rising edge acts.
REQ-013 autosave_en  in  1  enables timed autosave.
REQ-014 nvram_we  in  1  core write strobe to backup RAM.
REQ-015 sd_ack  in  1  sector transfer acknowledge from HPS.
REQ-016 sd_lba  out  32  sector address.
REQ-017 sd_rd  out  1  sector read request.
REQ-018 sd_wr  out  1  sector write request.
REQ-019 ena  out  1  writable save image present.
REQ-020 loading  out  1  load transfer active (core held in reset by its user).
REQ-021 busy  out  1  any transfer active.
REQ-022 dirty  out  1  backup RAM modified since last load/save.
REQ-023 done  out  1  one-cycle pulse at transfer completion.

Function
REQ-024 ena: cleared on download rising edge; set in any cycle with download & img_mounted & ~img_readonly; power-up 0; unaffected by reset.
REQ-025 Rising edges of load_req/save_req detected against previous-cycle registered copies gated by ena; with ena=0, edges ignored.
REQ-026 States: IDLE, ISSUE, WAIT_FALL.
REQ-027 IDLE start sources, priority high to low: download falling edge with img_size!=0 and ena (auto-load); load edge; save edge; autosave trigger.
REQ-028 Start: sd_lba<=0, busy<=1, loading<=1 for load / 0 for save, sd_rd<=load, sd_wr<=~load, state<=ISSUE.
REQ-029 ISSUE: on sd_ack rising edge clear sd_rd and sd_wr, go WAIT_FALL; requests stay asserted until then.
REQ-030 WAIT_FALL: on sd_ack falling edge, if sd_lba[SECTOR_BITS-1:0] all ones -> IDLE, busy<=0, loading<=0, done<=1 for one cycle; else sd_lba<=sd_lba+1, re-assert sd_rd/sd_wr per direction, go ISSUE.
REQ-031 sd_lba bits above SECTOR_BITS-1 always 0; no wrap beyond last sector.
REQ-032 load/save edges and autosave arriving while busy are dropped, not queued.
REQ-033 dirty: set on nvram_we when loading=0; cleared at save start and at load completion; nvram_we in the save-start cycle or during save leaves dirty=1 (set wins).
REQ-034 Autosave timer: cleared on nvram_we, on any start, or when dirty=0; otherwise increments while IDLE, dirty, ena, autosave_en; saturates at AUTOSAVE_DELAY.
REQ-035 Autosave trigger: timer==AUTOSAVE_DELAY in IDLE with dirty, ena, autosave_en; starts a save.
REQ-036 sd_ack edges detected against a registered copy; ack edge in IDLE ignored.

Reset
REQ-037 reset=1: state IDLE, sd_lba=0, sd_rd=0, sd_wr=0, busy=0, loading=0, dirty=0, done=0, timer=0, edge-detect registers loaded with current inputs.
REQ-038 Reset mid-transfer aborts at once; no done pulse; sd_lba returns to 0.
REQ-039 Power-up values equal reset values; ena=0.

Verification
REQ-040 Download with img_mounted, img_readonly=0, img_size=32768, download falls -> ena=1, loading=1, sd_rd=1, sd_lba 0..63 over 64 ack pulses, done pulse, loading=0.
REQ-041 ena=1, save_req rises, SECTOR_BITS=2 -> sd_wr for lba 0,1,2,3, sd_rd never 1, dirty=0 at start, done after 4th ack fall.
REQ-042 load_req and save_req rise same cycle -> load performed only.
REQ-043 AUTOSAVE_DELAY=100, autosave_en=1, one nvram_we -> save starts 101 cycles later; second nvram_we at cycle 50 delays start to 101 cycles after it.
REQ-044 Reset asserted during sector 3 wait -> next cycle sd_rd=sd_wr=0, sd_lba=0, busy=0, no done.
REQ-045 img_readonly=1 at mount -> ena=0; load/save edges produce no sd_rd/sd_wr.
